// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: walks each instruction through fetch, decode,
// execute, memory and write-back, and drives datapath selects and strobes.
//
// state  | meaning
// IDLE   | post-reset, all outputs quiet, moves to FETCH next cycle
// FETCH  | instruction memory request held until ack, IR latched on ack
// DECODE | one cycle to classify the instruction held in IR
// EXEC   | ALU operates; branches resolve and retire here
// MEM    | data memory request held until ack; stores retire on ack
// WB     | register file and PC written, instruction retires
// FAULT  | unsupported instruction or memory timeout, held until reset
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_br_less,
  input  logic        i_br_equal,
  input  logic        i_imem_ack,
  input  logic        i_dmem_ack,
  output logic        o_imem_req,
  output logic        o_ir_wren,
  output logic        o_pc_wren,
  output logic        o_br_sel,
  output logic        o_br_unsigned,
  output logic        o_rd_wren,
  output logic        o_mem_rden,
  output logic        o_mem_wren,
  output logic        o_op_a_sel,
  output logic        o_op_b_sel,
  output logic [3:0]  o_alu_op,
  output logic [1:0]  o_wb_sel,
  output logic        o_insn_done,
  output logic        o_fault,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_OPIMM, C_OP, C_BAD
  } class_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t      state_q, state_d;
  class_t      cls;
  logic [7:0]  wait_q;
  logic [31:0] instret_q;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic        taken;
  logic        wait_hit;
  logic        dp_a, dp_b;
  logic [3:0]  dp_alu;
  logic        unused_instr;

  assign opcode       = i_instr[6:0];
  assign funct3       = i_instr[14:12];
  assign alt          = i_instr[30];
  // Register and immediate fields belong to the datapath, not to this block.
  assign unused_instr = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};
  assign wait_hit     = (wait_q == WAIT_MAX);
  assign o_instret    = instret_q;

  // Classify the instruction held in IR; anything unrecognised is C_BAD.
  always_comb begin
    cls = C_BAD;
    case (opcode)
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1101111: cls = C_JAL;
      7'b1100111: if (funct3 == 3'b000) cls = C_JALR;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011) cls = C_BRANCH;
      7'b0000011: if (funct3 == 3'b010) cls = C_LOAD;
      7'b0100011: if (funct3 == 3'b010) cls = C_STORE;
      7'b0010011: cls = C_OPIMM;
      7'b0110011: cls = C_OP;
      default:    cls = C_BAD;
    endcase
  end

  // Operand selects and ALU operation per instruction class.
  always_comb begin
    dp_a   = 1'b0;
    dp_b   = 1'b0;
    dp_alu = 4'd0;
    case (cls)
      C_LUI: begin
        dp_b   = 1'b1;
        dp_alu = 4'd10;
      end
      C_AUIPC, C_JAL, C_BRANCH: begin
        dp_a = 1'b1;
        dp_b = 1'b1;
      end
      C_JALR, C_LOAD, C_STORE: dp_b = 1'b1;
      C_OPIMM, C_OP: begin
        dp_b = (cls == C_OPIMM);
        case (funct3)
          3'b000:  dp_alu = (cls == C_OP && alt) ? 4'd1 : 4'd0;
          3'b001:  dp_alu = 4'd7;
          3'b010:  dp_alu = 4'd2;
          3'b011:  dp_alu = 4'd3;
          3'b100:  dp_alu = 4'd4;
          3'b101:  dp_alu = alt ? 4'd9 : 4'd8;
          3'b110:  dp_alu = 4'd5;
          default: dp_alu = 4'd6;
        endcase
      end
      default: ;
    endcase
  end

  // Branch condition from comparator flags; odd funct3 inverts the sense.
  always_comb begin
    case (funct3)
      3'b000:         taken = i_br_equal;
      3'b001:         taken = !i_br_equal;
      3'b100, 3'b110: taken = i_br_less;
      3'b101, 3'b111: taken = !i_br_less;
      default:        taken = 1'b0;
    endcase
  end

  // Next state and per-state outputs; strobes are suppressed in a reset cycle.
  always_comb begin
    state_d       = state_q;
    o_imem_req    = 1'b0;
    o_ir_wren     = 1'b0;
    o_pc_wren     = 1'b0;
    o_br_sel      = 1'b0;
    o_br_unsigned = 1'b0;
    o_rd_wren     = 1'b0;
    o_mem_rden    = 1'b0;
    o_mem_wren    = 1'b0;
    o_op_a_sel    = 1'b0;
    o_op_b_sel    = 1'b0;
    o_alu_op      = 4'd0;
    o_wb_sel      = 2'd0;
    o_insn_done   = 1'b0;
    o_fault       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_wren = 1'b1;
          state_d   = S_DECODE;
        end else if (wait_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: state_d = (cls == C_BAD) ? S_FAULT : S_EXEC;
      S_EXEC: begin
        o_op_a_sel = dp_a;
        o_op_b_sel = dp_b;
        o_alu_op   = dp_alu;
        if (cls == C_BRANCH) begin
          o_br_unsigned = funct3[1];
          o_br_sel      = taken;
          o_pc_wren     = 1'b1;
          o_insn_done   = 1'b1;
          state_d       = S_FETCH;
        end else if (cls == C_LOAD || cls == C_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        o_op_a_sel = dp_a;
        o_op_b_sel = dp_b;
        o_alu_op   = dp_alu;
        o_mem_rden = (cls == C_LOAD);
        o_mem_wren = (cls == C_STORE);
        if (i_dmem_ack) begin
          if (cls == C_STORE) begin
            o_pc_wren   = 1'b1;
            o_insn_done = 1'b1;
            state_d     = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        o_op_a_sel  = dp_a;
        o_op_b_sel  = dp_b;
        o_alu_op    = dp_alu;
        o_rd_wren   = 1'b1;
        o_pc_wren   = 1'b1;
        o_insn_done = 1'b1;
        o_br_sel    = (cls == C_JAL || cls == C_JALR);
        if (cls == C_LOAD)                    o_wb_sel = 2'd1;
        else if (cls == C_JAL || cls == C_JALR) o_wb_sel = 2'd2;
        state_d = S_FETCH;
      end
      S_FAULT: o_fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (!i_rst_n) begin
      o_imem_req  = 1'b0;
      o_ir_wren   = 1'b0;
      o_pc_wren   = 1'b0;
      o_rd_wren   = 1'b0;
      o_mem_rden  = 1'b0;
      o_mem_wren  = 1'b0;
      o_insn_done = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Wait counter: zero on any state change, counts cycles spent waiting for ack.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                                   wait_q <= '0;
    else if (state_d != state_q)                    wait_q <= '0;
    else if (state_q == S_FETCH || state_q == S_MEM) wait_q <= wait_q + 8'd1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)         instret_q <= '0;
    else if (o_insn_done) instret_q <= instret_q + 32'd1;
  end

endmodule
